// File: rtl/vga_timing_pkg.sv
// Default 800x600@72 raster timing and shared types for the VGA scan path.
// Imported by the scan controller top.
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam logic [9:0] OUT_OF_RANGE_COORD   = 10'h3FF;
    localparam bit         SYNC_ACTIVE_HIGH_DEF = 1'b1;

    // Control bits that travel alongside the pixel read latency.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
        logic sof;
    } scan_ctrl_t;

    function automatic logic sync_level(input logic active, input bit active_high);
        return active ? active_high : ~active_high;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-qualified shift register with a per-instance asynchronous reset value.
// DEPTH must be at least 1; callers bypass it for zero delay.
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] reset_value,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: this array is a handful of control flops, so every stage is reset to the idle value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= reset_value;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster generator: issues row/col reads to the Mandelbrot computer and
// re-aligns sync/blank to the returned pixel before driving the DAC pins.
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE        = H_VISIBLE_DEF,
    parameter int H_FRONT          = H_FRONT_DEF,
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BACK           = H_BACK_DEF,
    parameter int V_VISIBLE        = V_VISIBLE_DEF,
    parameter int V_FRONT          = V_FRONT_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BACK           = V_BACK_DEF,
    parameter bit SYNC_ACTIVE_HIGH = SYNC_ACTIVE_HIGH_DEF,
    parameter int PIXEL_LATENCY    = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        pixel_ce,
    output logic [9:0]  vga_row,
    output logic [9:0]  vga_col,
    input  logic [23:0] pixel_in,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic [23:0] vga_rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam scan_ctrl_t CTRL_IDLE = '{
        hsync:   sync_level(1'b0, SYNC_ACTIVE_HIGH),
        vsync:   sync_level(1'b0, SYNC_ACTIVE_HIGH),
        visible: 1'b0,
        sof:     1'b0
    };

    logic [10:0] h_cnt, v_cnt, h_next, v_next;
    scan_ctrl_t  ctrl_now, ctrl_s0, ctrl_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        h_next = h_cnt + 11'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = '0;
            v_next = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pixel_ce) begin
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    always_comb begin
        ctrl_now.visible = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        ctrl_now.hsync   = sync_level((h_cnt >= HS_START) && (h_cnt < HS_END), SYNC_ACTIVE_HIGH);
        ctrl_now.vsync   = sync_level((v_cnt >= VS_START) && (v_cnt < VS_END), SYNC_ACTIVE_HIGH);
        ctrl_now.sof     = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    // Stage 0: read address to the computer plus the raw control bits for it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_s0 <= CTRL_IDLE;
            vga_row <= OUT_OF_RANGE_COORD;
            vga_col <= OUT_OF_RANGE_COORD;
        end else if (pixel_ce) begin
            ctrl_s0 <= ctrl_now;
            vga_row <= ctrl_now.visible ? v_cnt[9:0] : OUT_OF_RANGE_COORD;
            vga_col <= ctrl_now.visible ? h_cnt[9:0] : OUT_OF_RANGE_COORD;
        end
    end

    generate
        if (PIXEL_LATENCY == 0) begin : g_bypass
            assign ctrl_d = ctrl_s0;
        end else begin : g_delay
            sync_delay_line #(
                .DEPTH (PIXEL_LATENCY),
                .WIDTH ($bits(scan_ctrl_t))
            ) u_ctrl_delay (
                .clock       (clock),
                .reset_n     (reset_n),
                .en          (pixel_ce),
                .reset_value (CTRL_IDLE),
                .d           (ctrl_s0),
                .q           (ctrl_d)
            );
        end
    endgenerate

    // pixel_in is only looked at for visible slots, so blanking-time X never reaches the pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vga_rgb     <= '0;
            vga_blank_n <= 1'b0;
            vga_hsync   <= CTRL_IDLE.hsync;
            vga_vsync   <= CTRL_IDLE.vsync;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_ce & ctrl_d.sof;
            if (pixel_ce) begin
                vga_rgb     <= ctrl_d.visible ? pixel_in : 24'h000000;
                vga_blank_n <= ctrl_d.visible;
                vga_hsync   <= ctrl_d.hsync;
                vga_vsync   <= ctrl_d.vsync;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller: two instances (latency 1 / active-high sync and
// latency 3 / active-low sync) on a shrunken raster, checked against a position model.
module tb_vga_scan_controller;

    localparam int HV = 16, HF = 3, HS = 4, HB = 5;
    localparam int VV = 10, VF = 2, VS = 3, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int LAT_A = 1, LAT_B = 3;
    localparam bit POL_A = 1'b1, POL_B = 1'b0;

    typedef struct packed {
        logic [9:0]  row;
        logic [9:0]  col;
        logic        hs;
        logic        vs;
        logic        bn;
        logic [23:0] rgb;
        logic        fs;
    } pins_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pixel_ce = 1'b0;
    logic [9:0]  row_a, col_a, row_b, col_b;
    logic [23:0] pin_a, pin_b, rgb_a, rgb_b;
    logic        hs_a, vs_a, bn_a, fs_a, hs_b, vs_b, bn_b, fs_b;

    int          n_en = 0;
    bit          ce_last = 1'b0;
    logic [23:0] salt = 24'h0;
    int          tests_run = 0;
    int          tests_failed = 0;

    always #5 clock = ~clock;

    vga_scan_controller #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_HIGH(POL_A), .PIXEL_LATENCY(LAT_A)
    ) u_dut_a (
        .clock(clock), .reset_n(reset_n), .pixel_ce(pixel_ce),
        .vga_row(row_a), .vga_col(col_a), .pixel_in(pin_a),
        .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_blank_n(bn_a),
        .vga_rgb(rgb_a), .frame_start(fs_a)
    );

    vga_scan_controller #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_HIGH(POL_B), .PIXEL_LATENCY(LAT_B)
    ) u_dut_b (
        .clock(clock), .reset_n(reset_n), .pixel_ce(pixel_ce),
        .vga_row(row_b), .vga_col(col_b), .pixel_in(pin_b),
        .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_blank_n(bn_b),
        .vga_rgb(rgb_b), .frame_start(fs_b)
    );

    // Stand-in for the Mandelbrot computer: read pipelines of the configured depth.
    logic [19:0] pipe_a [1];
    logic [19:0] pipe_b [3];

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_a[0] <= '1;
            for (int i = 0; i < 3; i++) pipe_b[i] <= '1;
        end else if (pixel_ce) begin
            pipe_a[0] <= {row_a, col_a};
            pipe_b[0] <= {row_b, col_b};
            pipe_b[1] <= pipe_b[0];
            pipe_b[2] <= pipe_b[1];
        end
    end

    function automatic logic [23:0] computer_read(input logic [19:0] a, input logic [23:0] s);
        if (a[19:10] == 10'h3FF || a[9:0] == 10'h3FF) return 24'bx;
        return {4'h0, a} ^ s;
    endfunction

    assign pin_a = computer_read(pipe_a[0], salt);
    assign pin_b = computer_read(pipe_b[2], salt);

    function automatic logic [23:0] pix(input int v, input int h);
        return {4'h0, 10'(v), 10'(h)} ^ salt;
    endfunction

    // Pins expected after n enables since reset release: row/col show raster position n-1,
    // the DAC pins show position n-lat-2.
    function automatic pins_t model(input int lat, input bit pol, input int n, input bit ce);
        pins_t e;
        int p, h, v;
        bit vis;
        e.row = 10'h3FF; e.col = 10'h3FF;
        e.hs = ~pol; e.vs = ~pol; e.bn = 1'b0; e.rgb = 24'h0; e.fs = 1'b0;
        if (n >= 1) begin
            p = n - 1; h = p % HT; v = (p / HT) % VT;
            if (h < HV && v < VV) begin
                e.row = 10'(v);
                e.col = 10'(h);
            end
        end
        if (n >= lat + 2) begin
            p = n - lat - 2; h = p % HT; v = (p / HT) % VT;
            vis = (h < HV) && (v < VV);
            e.bn  = vis;
            e.rgb = vis ? pix(v, h) : 24'h0;
            e.hs  = (h >= HV + HF && h < HV + HF + HS) ? pol : ~pol;
            e.vs  = (v >= VV + VF && v < VV + VF + VS) ? pol : ~pol;
            e.fs  = ce && h == 0 && v == 0;
        end
        return e;
    endfunction

    function automatic pins_t expect_pins(input int i);
        return (i == 0) ? model(LAT_A, POL_A, n_en, ce_last) : model(LAT_B, POL_B, n_en, ce_last);
    endfunction

    function automatic pins_t observe(input int i);
        if (i == 0) return pins_t'({row_a, col_a, hs_a, vs_a, bn_a, rgb_a, fs_a});
        return pins_t'({row_b, col_b, hs_b, vs_b, bn_b, rgb_b, fs_b});
    endfunction

    task automatic clk_step(input bit ce);
        pixel_ce = ce;
        @(posedge clock);
        if (ce && reset_n) n_en++;
        ce_last = ce;
        @(negedge clock);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            clk_step(1'b1);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL reset dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_first_frame();
        int fs_count = 0, run = 0, max_run = 0;
        for (int k = 0; k < FRAME + 8; k++) begin
            clk_step(1'b1);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL first_frame dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
            if (n_en == LAT_A + 2) begin
                tests_run++;
                if (rgb_a !== pix(0, 0) || bn_a !== 1'b1 || fs_a !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL first_pixel got rgb=%h bn=%b fs=%b exp rgb=%h bn=1 fs=1", rgb_a, bn_a, fs_a, pix(0, 0));
                end
            end
            if (fs_a === 1'b1) fs_count++;
            run = (bn_a === 1'b1) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        tests_run++;
        if (fs_count != 2) begin
            tests_failed++;
            $display("FAIL frame_start_count got=%0d exp=2", fs_count);
        end
        tests_run++;
        if (max_run != HV) begin
            tests_failed++;
            $display("FAIL blank_n_run got=%0d exp=%0d", max_run, HV);
        end
    endtask

    task automatic test_frame_timing();
        int   hrise = -1, vrise = -1, last_fs = -1;
        logic prev_hs = hs_a, prev_vs = vs_a;
        for (int k = 0; k < 2 * FRAME + 2 * HT; k++) begin
            clk_step(1'b1);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL frame_timing dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
            if (hs_a === 1'b1 && prev_hs === 1'b0) begin
                tests_run++;
                if ((n_en - LAT_A - 2) % HT != HV + HF) begin
                    tests_failed++;
                    $display("FAIL hsync_rise_pos got=%0d exp=%0d", (n_en - LAT_A - 2) % HT, HV + HF);
                end
                if (hrise >= 0) begin
                    tests_run++;
                    if (n_en - hrise != HT) begin
                        tests_failed++;
                        $display("FAIL hsync_period got=%0d exp=%0d", n_en - hrise, HT);
                    end
                end
                hrise = n_en;
            end
            if (hs_a === 1'b0 && prev_hs === 1'b1 && hrise >= 0) begin
                tests_run++;
                if (n_en - hrise != HS) begin
                    tests_failed++;
                    $display("FAIL hsync_width got=%0d exp=%0d", n_en - hrise, HS);
                end
            end
            if (vs_a === 1'b1 && prev_vs === 1'b0) vrise = n_en;
            if (vs_a === 1'b0 && prev_vs === 1'b1 && vrise >= 0) begin
                tests_run++;
                if (n_en - vrise != VS * HT) begin
                    tests_failed++;
                    $display("FAIL vsync_width got=%0d exp=%0d", n_en - vrise, VS * HT);
                end
            end
            if (fs_a === 1'b1) begin
                if (last_fs >= 0) begin
                    tests_run++;
                    if (n_en - last_fs != FRAME) begin
                        tests_failed++;
                        $display("FAIL frame_period got=%0d exp=%0d", n_en - last_fs, FRAME);
                    end
                end
                last_fs = n_en;
            end
            prev_hs = hs_a;
            prev_vs = vs_a;
        end
    endtask

    task automatic test_half_rate();
        for (int k = 0; k < 2 * FRAME + 16; k++) begin
            clk_step(k % 2 == 0);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL half_rate dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
        end
    endtask

    task automatic test_random_ce();
        for (int k = 0; k < 1500; k++) begin
            clk_step($urandom_range(0, 2) != 0);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL random_ce dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
        end
    endtask

    task automatic test_mid_frame_reset();
        bit found = 1'b0;
        int first_fs [2] = '{-1, -1};
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            clk_step(1'b1);
            found = ((n_en - 1) % FRAME) == 6 * HT + 8;
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL reset_target_timeout got=not_reached exp=row6_col8");
        end
        reset_n = 1'b0;
        n_en = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tests_run++;
            if (observe(i) !== expect_pins(i)) begin
                tests_failed++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", i, observe(i), expect_pins(i));
            end
        end
        for (int k = 0; k < 2; k++) begin
            clk_step(1'b1);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL reset_hold dut%0d got=%h exp=%h", i, observe(i), expect_pins(i));
                end
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k < LAT_B + 6; k++) begin
            clk_step(1'b1);
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (observe(i) !== expect_pins(i)) begin
                    tests_failed++;
                    $display("FAIL post_reset dut%0d n=%0d got=%h exp=%h", i, n_en, observe(i), expect_pins(i));
                end
            end
            if (fs_a === 1'b1 && first_fs[0] < 0) first_fs[0] = n_en;
            if (fs_b === 1'b1 && first_fs[1] < 0) first_fs[1] = n_en;
        end
        tests_run++;
        if (first_fs[0] != LAT_A + 2) begin
            tests_failed++;
            $display("FAIL restart_fs_a got=%0d exp=%0d", first_fs[0], LAT_A + 2);
        end
        tests_run++;
        if (first_fs[1] != LAT_B + 2) begin
            tests_failed++;
            $display("FAIL restart_fs_b got=%0d exp=%0d", first_fs[1], LAT_B + 2);
        end
    endtask

    initial begin
        salt = 24'($urandom());
        test_reset();
        test_first_frame();
        test_frame_timing();
        test_half_rate();
        test_random_ce();
        test_mid_frame_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
